// File: rtl/if_pc_gen.sv
// Fetch PC generator: registered next-PC select (flush > stall > branch > pending > +PC_STEP), one-edge redirect latency.
// Stall holds the PC and parks a branch target until release; no combinational path from inputs to pc_o.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        redirect_pending_o
);

  logic        pending_valid;
  logic [31:0] pending_pc;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      ce_o          <= 1'b0;
      pc_o          <= RESET_PC;
      pending_valid <= 1'b0;
      pending_pc    <= 32'd0;
    end else begin
      ce_o <= 1'b1;
      // The first enabled cycle must fetch the boot vector, so redirects are ignored until ce_o rises.
      if (!ce_o) begin
        pc_o <= RESET_PC;
      end else if (flush_i) begin
        pc_o          <= flush_pc_i;
        pending_valid <= 1'b0;
      end else if (stall_i) begin
        if (branch_flag_i) begin
          pending_valid <= 1'b1;
          pending_pc    <= branch_target_i;
        end
      end else if (branch_flag_i) begin
        pc_o          <= branch_target_i;
        pending_valid <= 1'b0;
      end else if (pending_valid) begin
        pc_o          <= pending_pc;
        pending_valid <= 1'b0;
      end else begin
        pc_o <= pc_o + PC_STEP;
      end
    end
  end

  assign redirect_pending_o = pending_valid;

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboarded bench for if_pc_gen: directed bring-up/stall/flush/wrap/reset cases, then random traffic.
module tb_if_pc_gen;

  localparam logic [31:0] RST_VEC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = 32'd0;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        pend_o;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state: the fetch PC, whether fetching is enabled, and a
  // list of parked branch targets (at most one survives; newest wins).
  logic        m_ce = 1'b0;
  logic [31:0] m_pc = RST_VEC;
  logic [31:0] m_park[$];

  if_pc_gen dut (
    .cpu_clk_50M       (clk),
    .cpu_rst           (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .flush_pc_i        (flush_pc),
    .branch_flag_i     (br),
    .branch_target_i   (br_tgt),
    .pc_o              (pc_o),
    .ce_o              (ce_o),
    .redirect_pending_o(pend_o)
  );

  initial forever #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge and predict the state after the next rising edge.
  task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                       input logic b, input logic [31:0] bt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; flush_pc = fpc; br = b; br_tgt = bt;
    if (r) begin
      m_ce = 1'b0;
      m_pc = RST_VEC;
      m_park.delete();
    end else if (!m_ce) begin
      m_ce = 1'b1;
      m_pc = RST_VEC;
    end else if (f) begin
      m_pc = fpc;
      m_park.delete();
    end else if (s) begin
      if (b) m_park.push_back(bt);
    end else if (b) begin
      m_pc = bt;
      m_park.delete();
    end else if (m_park.size() != 0) begin
      m_pc = m_park[$];
      m_park.delete();
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.ce = m_ce;
    e.pc = m_pc;
    e.pend = (m_park.size() != 0);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic stall_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Monitor: one expected state per rising edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (ce_o !== e.ce || pc_o !== e.pc || pend_o !== e.pend) begin
        errors++;
        $display("FAIL state t=%0t: got ce=%b pc=%h pend=%b, expected ce=%b pc=%h pend=%b",
                 $time, ce_o, pc_o, pend_o, e.ce, e.pc, e.pend);
      end
    end
  end

  initial begin
    logic [31:0] t;
    int          wait_cnt;

    // Reset bring-up, then count up to BFC00010.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(5);
    // Stall hold for 4 cycles, release to BFC00014, advance to BFC00020.
    stall_n(4);
    idle(4);
    // Branch during stall, held 2 more cycles, then release.
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h8000_1000);
    stall_n(2);
    idle(2);
    // Flush overrides a pending redirect while stalled.
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h8000_1000);
    cycle(1'b0, 1'b1, 1'b1, 32'h8000_0180, 1'b0, 32'd0);
    idle(2);
    // Wrap-around and misaligned targets.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0002);
    idle(2);
    // Newer branch overwrites a pending one; live branch beats a stale pending entry.
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h1111_0000);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h2222_0000);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3333_0000);
    idle(1);
    // Reset mid-pending, with flush/branch asserted on the first enable edge.
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h1234_5678);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h8000_0180, 1'b1, 32'h1234_5678);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'b00;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), $urandom,
            ($urandom_range(0, 4) == 0), t);
    end

    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected states left unchecked, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Program-counter generator at the head of the fetch path.
- Holds the architectural fetch PC and produces the fetch address and chip-enable consumed by the IF stage.
- Selects the next PC from reset vector, exception/ERET redirect, ID-stage branch redirect, a buffered (pending) redirect, or sequential PC+4.
- Buffers a branch redirect that arrives while the front end is stalled and applies it once the stall releases.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded at reset (MIPS boot vector).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- cpu_clk_50M  input  1  pipeline clock; all state updates on rising edge.
- cpu_rst  input  1  reset; synchronous, active-high.
- stall_i  input  1  IF-stage stall bit from stall controller; hold PC.
- flush_i  input  1  exception/ERET flush from exception unit.
- flush_pc_i  input  32  redirect target for flush (exception vector or EPC).
- branch_flag_i  input  1  taken branch/jump resolved in ID.
- branch_target_i  input  32  branch/jump target address.
- pc_o  output  32  current fetch PC, drives IF address input.
- ce_o  output  1  fetch chip-enable, drives IF enable input.
- redirect_pending_o  output  1  high while a buffered branch redirect is waiting.

Behaviour:
- Reset: all state is registered. On any rising edge with cpu_rst=1:
  - ce_o<=0, pc_o<=RESET_PC.
  - pending_valid<=0, pending_pc<=0.
  - Reset asserted mid-operation discards any pending redirect.
- Enable bring-up:
  - ce_o<=1 on every edge with cpu_rst=0.
  - While ce_o=0, pc_o<=RESET_PC and all other inputs are ignored, including flush_i and branch_flag_i.
  - So the first fetch of RESET_PC occurs in the cycle after the first non-reset edge, and PC advances from the following edge.
- Next-PC priority, evaluated at each edge with ce_o=1, highest first:
  1. flush_i=1: pc_o<=flush_pc_i and pending_valid<=0. Honoured even when stall_i=1; branch_flag_i is ignored.
  2. stall_i=1: pc_o held.
     - If branch_flag_i=1: pending_valid<=1, pending_pc<=branch_target_i.
     - A newer branch overwrites an existing pending entry.
     - Otherwise pending state is held.
  3. branch_flag_i=1 (no stall): pc_o<=branch_target_i and pending_valid<=0. A live branch beats a stale pending entry.
  4. pending_valid=1 (no stall, no branch): pc_o<=pending_pc and pending_valid<=0.
  5. Otherwise: pc_o<=pc_o+PC_STEP.
- Arithmetic: 32-bit unsigned add, modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000). No overflow flag.
- Alignment:
  - No alignment check here. Misaligned targets are passed to pc_o unchanged so the IF stage raises AdEL with the correct bad address.
  - Sequential steps preserve pc_o[1:0].
- Latency:
  - Any redirect sampled at edge N is visible on pc_o after edge N; no combinational path from inputs to pc_o.
  - Delay slot: the branch arrives while its delay slot is being fetched, so redirecting at the next edge fetches the target immediately after the delay slot.
- redirect_pending_o equals the pending_valid register.
- stall_i and flush_i both high: flush wins; the stall only blocks sequential/branch updates.

Test Plan:
- Reset bring-up: hold cpu_rst=1 for 3 cycles, then release.
  - Expect ce_o=0 and pc_o=BFC00000 during reset.
  - After the first free edge: ce_o=1, pc_o=BFC00000.
  - Following edges: pc_o=BFC00004, then BFC00008.
- Stall hold: stall_i=1 for 4 cycles at pc_o=BFC00010.
  - Expect pc_o constant at BFC00010.
  - After release: pc_o=BFC00014.
- Branch during stall:
  - At pc_o=BFC00020, stall_i=1 with branch_flag_i=1 and target=80001000 for 1 cycle, stall held 2 more cycles.
  - Expect redirect_pending_o=1 while stalled.
  - On release: pc_o=80001000, pending cleared, then 80001004.
- Flush overrides:
  - With pending=80001000 and stall_i=1, assert flush_i with flush_pc_i=80000180.
  - Expect pc_o=80000180 next cycle and redirect_pending_o=0.
  - After stall release: 80000184, not 80001000.
- Wrap and misalignment:
  - Branch to FFFFFFFC: expect pc_o=FFFFFFFC, then 00000000.
  - Branch to 80000002: expect pc_o=80000002, then 80000006, unchanged low bits.
- Reset mid-pending:
  - With redirect_pending_o=1, assert cpu_rst for 1 cycle.
  - Expect pending cleared, ce_o=0, and restart at BFC00000 with no jump to the old target.
